// File: rtl/ads1675_pkg.sv
// Shared constants and types for the ADS1675 frame packer.
// Also holds the sample-width legality check used by the top.
package ads1675_pkg;

    localparam int         AXIS_W    = 32;
    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        DROP
    } state_t;

    function automatic bit dw_ok(input int dw);
        return (dw >= 1) && (dw <= AXIS_W);
    endfunction

endpackage

// File: rtl/ads1675_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered output word.
// Occupancy counts the output register, so full/empty/free are exact.
module ads1675_sync_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   free_cnt
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   mcnt_q, mcnt_d;
    logic [AW:0]   cnt;
    logic [W-1:0]  dout_q, dout_d;
    logic          dval_q, dval_d;
    logic          rd_fire;
    logic          wr_fire;
    logic          load;

    always_comb begin
        cnt      = mcnt_q + (AW+1)'(dval_q);
        full     = (cnt == (AW+1)'(DEPTH));
        empty    = (cnt == '0);
        free_cnt = (AW+1)'(DEPTH) - cnt;
        rd_fire  = rd_en & dval_q;
        // A read in the same cycle frees the slot, so a full FIFO may still take a write
        wr_fire  = wr_en & (~full | rd_fire);
        load     = (mcnt_q != '0) & (~dval_q | rd_fire);
        wp_d     = wr_fire ? wp_q + AW'(1) : wp_q;
        rp_d     = load ? rp_q + AW'(1) : rp_q;
        mcnt_d   = mcnt_q + (AW+1)'(wr_fire) - (AW+1)'(load);
        dval_d   = load | (dval_q & ~rd_fire);
        dout_d   = load ? mem_q[rp_q] : dout_q;
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wp_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            mcnt_q <= '0;
            dout_q <= '0;
            dval_q <= 1'b0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            mcnt_q <= mcnt_d;
            dout_q <= dout_d;
            dval_q <= dval_d;
        end
    end

    assign rd_data  = dout_q;
    assign rd_valid = dval_q;

endmodule

// File: rtl/ads1675_frame_packer.sv
// Packs ADS1675 samples into whole frames on an AXI4-Stream master.
// Define ADS1675_FRAME_HEADER_EN to prefix each accepted frame with a header word.
module ads1675_frame_packer
    import ads1675_pkg::*;
#(
    parameter int DW         = 24,
    parameter int FRAME_LEN  = 64,
    parameter int FIFO_DEPTH = 256
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              en,
    input  logic [DW-1:0]     s_data,
    input  logic              s_valid,
    output logic [AXIS_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              overflow,
    input  logic              overflow_clr,
    output logic [15:0]       drop_cnt
);

`ifdef ADS1675_FRAME_HEADER_EN
    localparam int HDR_W = 1;
`else
    localparam int HDR_W = 0;
`endif
    localparam int FRAME_WORDS = FRAME_LEN + HDR_W;
    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int IW          = $clog2(FRAME_LEN);
    localparam int FW          = AXIS_W + 1;

    if (!dw_ok(DW)) begin : g_dw_chk
        $error("ads1675_frame_packer: DW must be 1..32");
    end

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [15:0]     seq_q, seq_d;
    logic [15:0]     drop_q, drop_d;
    logic            ovf_q, ovf_d;
`ifdef ADS1675_FRAME_HEADER_EN
    logic [FW-1:0]   skid_q, skid_d;
    logic            skid_vld_q, skid_vld_d;
`endif

    logic            wr_en;
    logic [FW-1:0]   wr_data;
    logic [FW-1:0]   rd_data;
    logic            rd_valid;
    logic            fifo_full;
    logic            fifo_empty;
    logic [AW:0]     free_cnt;
    logic [AW+1:0]   free_eff;
    logic            rd_fire;
    logic            fits;
    logic            last_smp;
    logic [AXIS_W-1:0] sx;

    always_comb begin
        rd_fire  = rd_valid & m_axis_tready;
        free_eff = {1'b0, free_cnt} + (AW+2)'(rd_fire);
        fits     = fifo_empty |
                   ((~fifo_full | rd_fire) &
                    (free_eff >= (AW+2)'(FRAME_WORDS)));
        last_smp = (idx_q == IW'(FRAME_LEN - 1));
        sx       = AXIS_W'(signed'(s_data));

        state_d = state_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        drop_d  = drop_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_data = '0;
`ifdef ADS1675_FRAME_HEADER_EN
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
`endif

        // Clear first so a drop in the same cycle wins
        if (overflow_clr) begin
            ovf_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (s_valid && en) begin
                    seq_d = seq_q + 16'd1;
                    idx_d = IW'(1);
                    if (fits) begin
                        state_d = ACCEPT;
                        wr_en   = 1'b1;
`ifdef ADS1675_FRAME_HEADER_EN
                        wr_data    = {1'b0, HDR_MAGIC, 8'h00, seq_q};
                        skid_d     = {1'b0, sx};
                        skid_vld_d = 1'b1;
`else
                        wr_data = {1'b0, sx};
`endif
                    end else begin
                        state_d = DROP;
                        ovf_d   = 1'b1;
                        if (drop_q != 16'hFFFF) begin
                            drop_d = drop_q + 16'd1;
                        end
                    end
                end
            end
            ACCEPT: begin
`ifdef ADS1675_FRAME_HEADER_EN
                if (skid_vld_q) begin
                    wr_en      = 1'b1;
                    wr_data    = skid_q;
                    skid_vld_d = 1'b0;
                end
`endif
                if (s_valid) begin
                    wr_en   = 1'b1;
                    wr_data = {last_smp, sx};
                    if (last_smp) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DROP: begin
                if (s_valid) begin
                    if (last_smp) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            seq_q   <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
`ifdef ADS1675_FRAME_HEADER_EN
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
`ifdef ADS1675_FRAME_HEADER_EN
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
`endif
        end
    end

    ads1675_sync_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (aclk),
        .rst      (areset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (m_axis_tready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .free_cnt (free_cnt)
    );

    assign m_axis_tdata  = rd_data[AXIS_W-1:0];
    assign m_axis_tlast  = rd_data[AXIS_W];
    assign m_axis_tvalid = rd_valid;
    assign overflow      = ovf_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_ads1675_frame_packer.sv
// Directed bench for ads1675_frame_packer with FRAME_LEN=4, FIFO_DEPTH=8.
// Header scenarios run when ADS1675_FRAME_HEADER_EN is defined.
module tb_ads1675_frame_packer;

    logic        aclk = 1'b0;
    logic        areset;
    logic        en;
    logic [23:0] s_data;
    logic        s_valid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        overflow;
    logic        overflow_clr;
    logic [15:0] drop_cnt;

    int errs   = 0;
    int checks = 0;
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];

    ads1675_frame_packer #(
        .DW         (24),
        .FRAME_LEN  (4),
        .FIFO_DEPTH (8)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .en            (en),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr),
        .drop_cnt      (drop_cnt)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (!areset && m_axis_tvalid && m_axis_tready)
            got_q.push_back({m_axis_tlast, m_axis_tdata});
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [23:0] d, input logic c = 1'b0);
        @(posedge aclk);
        #1 s_valid = 1'b1;
        s_data = d;
        overflow_clr = c;
        @(posedge aclk);
        #1 s_valid = 1'b0;
        overflow_clr = 1'b0;
    endtask

    task automatic push(input logic [23:0] d, input logic last);
        exp_q.push_back({last, {8{d[23]}}, d});
    endtask

    task automatic push_hdr(input logic [15:0] s);
        exp_q.push_back({1'b0, 8'hA5, 8'h00, s});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 60) begin
            @(posedge aclk);
            n++;
        end
        repeat (3) @(posedge aclk);
        chk({tag, "_cnt"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        #1 areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        areset        = 1'b1;
        en            = 1'b1;
        s_valid       = 1'b0;
        s_data        = '0;
        m_axis_tready = 1'b0;
        overflow_clr  = 1'b0;

        @(negedge aclk);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        @(posedge aclk);
        #1 areset = 1'b0;

        // Basic frame and first-word latency
        m_axis_tready = 1'b1;
        @(posedge aclk);
        #1 s_valid = 1'b1;
        s_data = 24'h7FFFFF;
        @(posedge aclk);
        #1 s_valid = 1'b0;
        @(negedge aclk);
        chk("lat_t1_tvalid", m_axis_tvalid, 0);
        @(negedge aclk);
        chk("lat_t2_tvalid", m_axis_tvalid, 1);
`ifdef ADS1675_FRAME_HEADER_EN
        chk("lat_t2_hdr", m_axis_tdata, 32'hA500_0000);
`else
        chk("lat_t2_tdata", m_axis_tdata, 32'h007F_FFFF);
`endif
        send(24'h800000);
        send(24'h000001);
        send(24'hFFFFFF);
`ifdef ADS1675_FRAME_HEADER_EN
        push_hdr(16'h0000);
`endif
        exp_q.push_back(33'h0_007F_FFFF);
        exp_q.push_back(33'h0_FF80_0000);
        exp_q.push_back(33'h0_0000_0001);
        exp_q.push_back(33'h1_FFFF_FFFF);
        drain("basic");

`ifdef ADS1675_FRAME_HEADER_EN
        // Header: frame 0 accepted, frame 1 dropped, frame 2 accepted
        do_reset();
        m_axis_tready = 1'b0;
        send(24'h000001); send(24'h000002);
        send(24'h000003); send(24'h000004);
        send(24'h000011); send(24'h000012);
        send(24'h000013); send(24'h000014);
        chk("hdr_ovf", overflow, 1);
        chk("hdr_drop", drop_cnt, 1);
        @(posedge aclk);
        #1 m_axis_tready = 1'b1;
        push_hdr(16'h0000);
        push(24'h000001, 0); push(24'h000002, 0);
        push(24'h000003, 0); push(24'h000004, 1);
        drain("hdr_f0");
        send(24'h800021); send(24'h000022);
        send(24'h000023); send(24'hFFFF24);
        push_hdr(16'h0002);
        push(24'h800021, 0); push(24'h000022, 0);
        push(24'h000023, 0); push(24'hFFFF24, 1);
        drain("hdr_f2");
`else
        // Backpressure: two frames stalled, then released
        m_axis_tready = 1'b0;
        send(24'h000011); send(24'h000022);
        send(24'h000033); send(24'h800044);
        send(24'h123456); send(24'hFEDCBA);
        send(24'h000000); send(24'h7FFFFF);
        @(negedge aclk);
        chk("bp_tvalid", m_axis_tvalid, 1);
        chk("bp_tdata0", m_axis_tdata, 32'h0000_0011);
        repeat (3) @(negedge aclk);
        chk("bp_stable", m_axis_tdata, 32'h0000_0011);
        chk("bp_tvalid_hold", m_axis_tvalid, 1);
        chk("bp_nodrop", drop_cnt, 0);
        @(posedge aclk);
        #1 m_axis_tready = 1'b1;
        push(24'h000011, 0); push(24'h000022, 0);
        push(24'h000033, 0); push(24'h800044, 1);
        push(24'h123456, 0); push(24'hFEDCBA, 0);
        push(24'h000000, 0); push(24'h7FFFFF, 1);
        drain("bp");

        // Overflow: third frame dropped whole
        m_axis_tready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) begin
                send(24'(32'h800100 + k * 16 + j));
                push(24'(32'h800100 + k * 16 + j), j == 3);
            end
        end
        chk("ovf_pre", overflow, 0);
        send(24'h000300);
        chk("ovf_set", overflow, 1);
        chk("ovf_drop1", drop_cnt, 1);
        send(24'h000301); send(24'h000302); send(24'h000303);
        @(posedge aclk);
        #1 m_axis_tready = 1'b1;
        drain("ovf");
        repeat (10) @(posedge aclk);
        chk("ovf_no_partial", got_q.size(), 0);

        // Clear in the same cycle as a new drop keeps the flag
        m_axis_tready = 1'b0;
        for (int j = 0; j < 8; j++) begin
            send(24'(32'h000400 + j));
            push(24'(32'h000400 + j), j == 3 || j == 7);
        end
        send(24'h000500, 1'b1);
        chk("clr_drop_ovf", overflow, 1);
        chk("clr_drop_cnt", drop_cnt, 2);
        send(24'h000501); send(24'h000502); send(24'h000503);
        @(posedge aclk);
        #1 overflow_clr = 1'b1;
        @(posedge aclk);
        #1 overflow_clr = 1'b0;
        chk("clr_only", overflow, 0);
        chk("clr_cnt_kept", drop_cnt, 2);
        m_axis_tready = 1'b1;
        drain("clr");

        // en dropped mid-frame does not cut the frame
        send(24'h000005);
        send(24'hFFFFFA);
        en = 1'b0;
        send(24'h000007);
        send(24'h800008);
        push(24'h000005, 0); push(24'hFFFFFA, 0);
        push(24'h000007, 0); push(24'h800008, 1);
        drain("en_mid");
        send(24'h000123);
        repeat (5) @(posedge aclk);
        chk("en_ignore", got_q.size(), 0);
        en = 1'b1;

        // Asynchronous reset mid-frame
        m_axis_tready = 1'b0;
        send(24'h000011);
        send(24'h000022);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("mrst_pre_tvalid", m_axis_tvalid, 1);
        #1 areset = 1'b1;
        #1;
        chk("mrst_tvalid", m_axis_tvalid, 0);
        chk("mrst_tdata", m_axis_tdata, 0);
        chk("mrst_tlast", m_axis_tlast, 0);
        chk("mrst_drop", drop_cnt, 0);
        @(posedge aclk);
        #1 areset = 1'b0;
        m_axis_tready = 1'b1;
        repeat (5) @(posedge aclk);
        @(negedge aclk);
        chk("mrst_empty", m_axis_tvalid, 0);
        chk("mrst_no_words", got_q.size(), 0);
        send(24'h0000A1); send(24'h0000A2);
        send(24'h0000A3); send(24'h0000A4);
        push(24'h0000A1, 0); push(24'h0000A2, 0);
        push(24'h0000A3, 0); push(24'h0000A4, 1);
        drain("mrst_after");
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
